srq_burst_drain: RTL and testbench

- Consumer end of a shift-register queue in the memory controller write-data path.
- Watches the queue's tail valid/data, pops one WIDTH-bit entry at a time, and serializes it into BEATS narrow beats on the DRAM-die data interface using a valid/ready handshake.
- Supports back-to-back entries with no bubble, an abort that discards the current burst, and a saturating count of completed bursts.

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/srq_burst_drain_beat_serializer.sv | 53 +++++
 rtl/srq_burst_drain.sv | 128 ++++++++++++
 tb/tb_srq_burst_drain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types and default widths for the write-data queue
// and its burst drain.
package mem_ctrl_pkg;

    typedef enum logic [0:0] {DRAIN_IDLE, DRAIN_SEND} drain_state_t;

    localparam int SRQ_WIDTH  = 1024;
    localparam int SRQ_BEAT_W = 128;

    function automatic int idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/srq_burst_drain_beat_serializer.sv
// Holds one queue entry and presents it as BEAT_W slices, LSB slice first,
// together with the running beat index and a last-beat indication.
module beat_serializer #(
    parameter int WIDTH  = 1024,
    parameter int BEAT_W = 128,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic [BEAT_W-1:0] beat_data_o,
    output logic [IDX_W-1:0]  beat_idx_o,
    output logic              beat_last_o
);

    localparam int BEATS = WIDTH / BEAT_W;

    logic [WIDTH-1:0] buf_q, buf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // A reload wins over an advance so back-to-back entries restart at beat 0.
    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (load_i) begin
            buf_d = data_i;
            idx_d = '0;
        end else if (advance_i) begin
            buf_d = buf_q >> BEAT_W;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

    assign beat_data_o = buf_q[BEAT_W-1:0];
    assign beat_idx_o  = idx_q;
    assign beat_last_o = (idx_q == IDX_W'(BEATS - 1));

endmodule

// File: rtl/srq_burst_drain.sv
// Consumer end of the write-data shift-register queue: pops one entry at a
// time and streams it as BEATS narrow beats over a valid/ready interface.
module srq_burst_drain
    import mem_ctrl_pkg::*;
#(
    parameter int  WIDTH  = SRQ_WIDTH,
    parameter int  BEAT_W = SRQ_BEAT_W,
    parameter int  CNT_W  = 16,
    localparam int BEATS  = WIDTH / BEAT_W,
    localparam int IDX_W  = idx_width(WIDTH / BEAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              abort,
    input  logic              q_out_valid,
    input  logic [WIDTH-1:0]  q_data_out,
    input  logic              q_empty,
    output logic              q_pop,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [BEAT_W-1:0] tx_data,
    output logic              tx_last,
    output logic [IDX_W-1:0]  tx_beat_idx,
    output logic              busy,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic              error_flag
);

    if (BEAT_W <= 0 || (WIDTH % BEAT_W) != 0) begin : g_bad_width
        $error("srq_burst_drain: WIDTH must be a multiple of BEAT_W");
    end

    drain_state_t     state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             error_q, error_d;

    logic can_pop, pop, clear, advance, credit;
    logic beat_last;

    assign can_pop = enable && q_out_valid && !abort;

    // Abort takes priority over any transfer outcome; a beat taken in the
    // abort cycle is still consumed downstream but earns no burst credit.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        clear   = 1'b0;
        advance = 1'b0;
        credit  = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = DRAIN_SEND;
                end
            end
            DRAIN_SEND: begin
                if (abort) begin
                    state_d = DRAIN_IDLE;
                    clear   = 1'b1;
                end else if (tx_ready) begin
                    if (beat_last) begin
                        credit = 1'b1;
                        if (can_pop) begin
                            pop = 1'b1;
                        end else begin
                            state_d = DRAIN_IDLE;
                            clear   = 1'b1;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
                clear   = 1'b1;
            end
        endcase
    end

    // Gating with rst keeps the queue from advancing while we are held in reset.
    assign q_pop = pop && rst;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (credit && (burst_cnt_q != {CNT_W{1'b1}})) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        error_d = error_q || (q_pop && !q_out_valid) || (q_out_valid && q_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DRAIN_IDLE;
            burst_cnt_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            error_q     <= error_d;
        end
    end

    beat_serializer #(
        .WIDTH  (WIDTH),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (q_pop),
        .clear_i     (clear),
        .advance_i   (advance),
        .data_i      (q_data_out),
        .beat_data_o (tx_data),
        .beat_idx_o  (tx_beat_idx),
        .beat_last_o (beat_last)
    );

    assign busy       = (state_q == DRAIN_SEND);
    assign tx_valid   = busy;
    assign tx_last    = busy && beat_last;
    assign burst_cnt  = burst_cnt_q;
    assign error_flag = error_q;

endmodule

// File: tb/tb_srq_burst_drain.sv
// Directed checks of the burst drain: single entry, back-to-back, backpressure,
// abort, enable gating, queue-flag error and mid-burst reset.
module tb_srq_burst_drain;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, abort, q_out_valid, q_empty, tx_ready;
    logic [1023:0] q_data_out;
    logic          q_pop, tx_valid, tx_last, busy, error_flag;
    logic [127:0]  tx_data;
    logic [2:0]    tx_beat_idx;
    logic [15:0]   burst_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    srq_burst_drain dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .abort       (abort),
        .q_out_valid (q_out_valid),
        .q_data_out  (q_data_out),
        .q_empty     (q_empty),
        .q_pop       (q_pop),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_beat_idx (tx_beat_idx),
        .busy        (busy),
        .burst_cnt   (burst_cnt),
        .error_flag  (error_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [1023:0] mk(input logic [7:0] base);
        logic [1023:0] r;
        for (int i = 0; i < 8; i++) r[i*128 +: 128] = 128'(base) + 128'(i);
        return r;
    endfunction

    // Each cycle: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}
    function automatic logic [133:0] beat_vec(input int b, input logic [7:0] base, input logic pop);
        return {1'b1, (b == 7), 3'(b), 128'(base) + 128'(b), pop};
    endfunction

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; abort = 1'b0; q_out_valid = 1'b0;
        q_empty = 1'b1; tx_ready = 1'b1; q_data_out = '0;
        #12;
        n_cmp++;
        if ({q_pop, tx_valid, tx_last, tx_beat_idx, tx_data, busy, burst_cnt, error_flag} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got pop=%0b val=%0b last=%0b idx=%0d data=%h busy=%0b cnt=%0d err=%0b want all 0",
                     q_pop, tx_valid, tx_last, tx_beat_idx, tx_data, busy, burst_cnt, error_flag);
        end
        cyc(); rst = 1'b1; q_empty = 1'b0;
    endtask

    task automatic test_single();
        cyc(); enable = 1'b1; q_out_valid = 1'b1; q_data_out = mk(8'h00); #1;
        n_cmp++;
        if ({q_pop, tx_valid} !== 2'b10) begin
            n_bad++; $display("FAIL single_pop: got pop=%0b valid=%0b want pop=1 valid=0", q_pop, tx_valid);
        end
        for (int b = 0; b < 8; b++) begin
            cyc(); q_out_valid = 1'b0; #1;
            n_cmp++;
            if ({tx_valid, tx_last, tx_beat_idx, tx_data, q_pop} !== beat_vec(b, 8'h00, 1'b0)) begin
                n_bad++; $display("FAIL single_beat%0d: got %h want %h", b,
                    {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}, beat_vec(b, 8'h00, 1'b0));
            end
        end
        cyc(); #1;
        n_cmp++;
        if ({tx_valid, busy, burst_cnt} !== {2'b00, 16'd1}) begin
            n_bad++; $display("FAIL single_end: got valid=%0b busy=%0b cnt=%0d want 0 0 1", tx_valid, busy, burst_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        cyc(); q_out_valid = 1'b1; q_data_out = mk(8'h10); #1;
        n_cmp++;
        if (q_pop !== 1'b1) begin
            n_bad++; $display("FAIL b2b_pop0: got %0b want 1", q_pop);
        end
        for (int b = 0; b < 16; b++) begin
            cyc();
            q_out_valid = (b == 7);
            q_data_out  = mk(8'h20);
            #1;
            base = (b < 8) ? 8'h10 : 8'h20;
            n_cmp++;
            if ({tx_valid, tx_last, tx_beat_idx, tx_data, q_pop} !== beat_vec(b % 8, base, b == 7)) begin
                n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", b,
                    {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}, beat_vec(b % 8, base, b == 7));
            end
        end
        cyc(); #1;
        n_cmp++;
        if ({tx_valid, burst_cnt} !== {1'b0, 16'd3}) begin
            n_bad++; $display("FAIL b2b_end: got valid=%0b cnt=%0d want 0 3", tx_valid, burst_cnt);
        end
    endtask

    task automatic test_backpressure();
        int idx_seq[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
        int rdy_seq[11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        cyc(); q_out_valid = 1'b1; q_data_out = mk(8'h30); #1;
        n_cmp++;
        if (q_pop !== 1'b1) begin
            n_bad++; $display("FAIL bp_pop: got %0b want 1", q_pop);
        end
        for (int c = 0; c < 11; c++) begin
            cyc(); q_out_valid = 1'b0; tx_ready = rdy_seq[c][0]; #1;
            n_cmp++;
            if ({tx_valid, tx_last, tx_beat_idx, tx_data, q_pop} !== beat_vec(idx_seq[c], 8'h30, 1'b0)) begin
                n_bad++; $display("FAIL bp_cycle%0d: got %h want %h", c,
                    {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}, beat_vec(idx_seq[c], 8'h30, 1'b0));
            end
        end
        cyc(); tx_ready = 1'b1; #1;
        n_cmp++;
        if ({tx_valid, burst_cnt} !== {1'b0, 16'd4}) begin
            n_bad++; $display("FAIL bp_end: got valid=%0b cnt=%0d want 0 4", tx_valid, burst_cnt);
        end
    endtask

    task automatic test_abort();
        cyc(); q_out_valid = 1'b1; q_data_out = mk(8'h40); #1;
        n_cmp++;
        if (q_pop !== 1'b1) begin
            n_bad++; $display("FAIL abort_pop: got %0b want 1", q_pop);
        end
        for (int b = 0; b < 5; b++) begin
            cyc(); q_out_valid = (b == 4); abort = (b == 4); q_data_out = mk(8'h50); #1;
            n_cmp++;
            if ({tx_valid, tx_last, tx_beat_idx, tx_data, q_pop} !== beat_vec(b, 8'h40, 1'b0)) begin
                n_bad++; $display("FAIL abort_beat%0d: got %h want %h", b,
                    {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}, beat_vec(b, 8'h40, 1'b0));
            end
        end
        cyc(); abort = 1'b0; q_out_valid = 1'b0; #1;
        n_cmp++;
        if ({tx_valid, q_pop, burst_cnt} !== {2'b00, 16'd4}) begin
            n_bad++; $display("FAIL abort_after: got valid=%0b pop=%0b cnt=%0d want 0 0 4", tx_valid, q_pop, burst_cnt);
        end
        cyc(); abort = 1'b1; q_out_valid = 1'b1; #1;
        n_cmp++;
        if (q_pop !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle_pop: got %0b want 0", q_pop);
        end
        cyc(); abort = 1'b0; q_out_valid = 1'b0; #1;
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle_valid: got %0b want 0", tx_valid);
        end
        cyc(); q_out_valid = 1'b1; #1;
        n_cmp++;
        if (q_pop !== 1'b1) begin
            n_bad++; $display("FAIL restart_pop: got %0b want 1", q_pop);
        end
        for (int b = 0; b < 8; b++) begin
            cyc(); q_out_valid = 1'b0; #1;
            n_cmp++;
            if ({tx_valid, tx_last, tx_beat_idx, tx_data, q_pop} !== beat_vec(b, 8'h50, 1'b0)) begin
                n_bad++; $display("FAIL restart_beat%0d: got %h want %h", b,
                    {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}, beat_vec(b, 8'h50, 1'b0));
            end
        end
        cyc(); #1;
        n_cmp++;
        if ({tx_valid, burst_cnt} !== {1'b0, 16'd5}) begin
            n_bad++; $display("FAIL restart_end: got valid=%0b cnt=%0d want 0 5", tx_valid, burst_cnt);
        end
    endtask

    task automatic test_enable();
        cyc(); enable = 1'b0; q_out_valid = 1'b1; q_data_out = mk(8'h60); #1;
        n_cmp++;
        if (q_pop !== 1'b0) begin
            n_bad++; $display("FAIL en_off_pop: got %0b want 0", q_pop);
        end
        cyc(); #1;
        n_cmp++;
        if ({tx_valid, q_pop} !== 2'b00) begin
            n_bad++; $display("FAIL en_off_idle: got valid=%0b pop=%0b want 0 0", tx_valid, q_pop);
        end
        cyc(); enable = 1'b1; #1;
        n_cmp++;
        if (q_pop !== 1'b1) begin
            n_bad++; $display("FAIL en_on_pop: got %0b want 1", q_pop);
        end
        for (int b = 0; b < 8; b++) begin
            cyc(); q_data_out = mk(8'h70); enable = (b < 3); #1;
            n_cmp++;
            if ({tx_valid, tx_last, tx_beat_idx, tx_data, q_pop} !== beat_vec(b, 8'h60, 1'b0)) begin
                n_bad++; $display("FAIL en_beat%0d: got %h want %h", b,
                    {tx_valid, tx_last, tx_beat_idx, tx_data, q_pop}, beat_vec(b, 8'h60, 1'b0));
            end
        end
        cyc(); #1;
        n_cmp++;
        if ({tx_valid, q_pop, burst_cnt} !== {2'b00, 16'd6}) begin
            n_bad++; $display("FAIL en_end: got valid=%0b pop=%0b cnt=%0d want 0 0 6", tx_valid, q_pop, burst_cnt);
        end
    endtask

    task automatic test_error_and_reset();
        cyc(); q_empty = 1'b1; #1;
        n_cmp++;
        if (error_flag !== 1'b0) begin
            n_bad++; $display("FAIL err_before: got %0b want 0", error_flag);
        end
        cyc(); q_empty = 1'b0; q_out_valid = 1'b0; #1;
        n_cmp++;
        if (error_flag !== 1'b1) begin
            n_bad++; $display("FAIL err_set: got %0b want 1", error_flag);
        end
        repeat (3) cyc();
        n_cmp++;
        if (error_flag !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky: got %0b want 1", error_flag);
        end
        cyc(); enable = 1'b1; q_out_valid = 1'b1; q_data_out = mk(8'h80); #1;
        n_cmp++;
        if (q_pop !== 1'b1) begin
            n_bad++; $display("FAIL rst_burst_pop: got %0b want 1", q_pop);
        end
        repeat (4) cyc();
        n_cmp++;
        if ({tx_valid, tx_beat_idx} !== {1'b1, 3'd3}) begin
            n_bad++; $display("FAIL rst_burst_mid: got valid=%0b idx=%0d want 1 3", tx_valid, tx_beat_idx);
        end
        rst = 1'b0; #1;
        n_cmp++;
        if ({q_pop, tx_valid, tx_last, tx_beat_idx, tx_data, busy, burst_cnt, error_flag} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got pop=%0b val=%0b last=%0b idx=%0d data=%h busy=%0b cnt=%0d err=%0b want all 0",
                     q_pop, tx_valid, tx_last, tx_beat_idx, tx_data, busy, burst_cnt, error_flag);
        end
        cyc();
        n_cmp++;
        if ({q_pop, tx_valid, busy, burst_cnt, error_flag} !== '0) begin
            n_bad++; $display("FAIL rst_held: got pop=%0b val=%0b busy=%0b cnt=%0d err=%0b want all 0",
                              q_pop, tx_valid, busy, burst_cnt, error_flag);
        end
        enable = 1'b0; q_out_valid = 1'b0; rst = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_enable();
        test_error_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
